// File: rtl/lmakeup_limiter.sv
// lmakeup_limiter: fixed make-up gain with saturation, followed by a lookahead
// brick-wall peak limiter. One sample in per i_ce, one sample out per o_ce,
// fixed 20-cycle latency (IDLE -> MAG -> DIV x16 -> APPLY x2 -> IDLE).
module lmakeup_limiter #(
    parameter int                  W_TOTAL      = 16,
    parameter int                  W_FRAC       = 15,
    parameter logic [W_TOTAL-1:0]  MAKEUP_GAIN  = 16'h6000,
    parameter logic [W_TOTAL-1:0]  CEIL_LIN     = 16'h7000,
    parameter int                  LOOKAHEAD    = 8,
    parameter logic [W_TOTAL-1:0]  RELEASE_STEP = 16'h0010
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic [W_TOTAL-1:0] i_data,
    output logic [W_TOTAL-1:0] o_data,
    output logic               o_ce,
    output logic [W_TOTAL-1:0] o_gain,
    output logic               o_overrun
);

    localparam int PW    = 2 * W_TOTAL + 1;          // full product width
    localparam int MK_SH = W_TOTAL - 2;              // Q2.14 make-up gain fraction
    localparam int AW    = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1;
    localparam int CW    = $clog2(LOOKAHEAD + 1);
    localparam int DW    = $clog2(W_TOTAL);

    localparam logic [CW-1:0] LA      = CW'(LOOKAHEAD);
    localparam logic [AW-1:0] LAST_WP = AW'(LOOKAHEAD - 1);
    localparam logic [DW-1:0] LAST_DV = DW'(W_TOTAL - 1);

    localparam logic signed [W_TOTAL-1:0] SMAX = {1'b0, {(W_TOTAL-1){1'b1}}};
    localparam logic signed [W_TOTAL-1:0] SMIN = {1'b1, {(W_TOTAL-1){1'b0}}};
    localparam logic signed [PW-1:0] PMAX = {{(PW-W_TOTAL+1){1'b0}}, {(W_TOTAL-1){1'b1}}};
    localparam logic signed [PW-1:0] PMIN = {{(PW-W_TOTAL+1){1'b1}}, {(W_TOTAL-1){1'b0}}};
    localparam logic [W_TOTAL-1:0] ONE = {1'b1, {(W_TOTAL-1){1'b0}}};

    // Dividend CEIL_LIN << W_FRAC, split into the initial partial remainder
    // (upper half) and the bits shifted in one per iteration (lower half).
    localparam logic [2*W_TOTAL-1:0] DVD =
        {{(W_TOTAL-W_FRAC){1'b0}}, CEIL_LIN, {W_FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, MAG, DIV, APPLY} state_t;

    state_t                      state_q, state_d;
    logic signed [W_TOTAL-1:0]   s_q, s_d;
    logic signed [W_TOTAL-1:0]   d_q, d_d;
    logic [W_TOTAL-1:0]          peak_q, peak_d;
    logic [CW-1:0]               hold_q, hold_d;
    logic [AW-1:0]               wptr_q, wptr_d;
    logic [CW-1:0]               fill_q, fill_d;
    logic signed [W_TOTAL-1:0]   mem_q [LOOKAHEAD];
    logic signed [W_TOTAL-1:0]   mem_d [LOOKAHEAD];
    logic [W_TOTAL-1:0]          rem_q, rem_d;
    logic [W_TOTAL-1:0]          dvd_q, dvd_d;
    logic [W_TOTAL-2:0]          quo_q, quo_d;
    logic [DW-1:0]               cnt_q, cnt_d;
    logic [W_TOTAL-1:0]          g_q, g_d;
    logic signed [PW-1:0]        prod_q, prod_d;
    logic [W_TOTAL-1:0]          o_data_q, o_data_d;
    logic [W_TOTAL-1:0]          o_gain_q, o_gain_d;
    logic                        o_ce_q, o_ce_d;
    logic                        ovr_q, ovr_d;

    logic signed [PW-1:0]        mk_full, mk_sh, y_full;
    logic signed [W_TOTAL-1:0]   s_sat, y_sat;
    logic [W_TOTAL-1:0]          m;
    logic [W_TOTAL:0]            r_sh;
    logic                        qbit;

    // Datapath helpers: make-up gain with saturation, |s|, divider step, output clamp.
    always_comb begin
        mk_full = $signed(i_data) * $signed({1'b0, MAKEUP_GAIN});
        mk_sh   = mk_full >>> MK_SH;
        if (mk_sh > PMAX)      s_sat = SMAX;
        else if (mk_sh < PMIN) s_sat = SMIN;
        else                   s_sat = mk_sh[W_TOTAL-1:0];

        if (s_q == SMIN)       m = SMAX;
        else if (s_q[W_TOTAL-1]) m = -s_q;
        else                   m = s_q;

        r_sh = {rem_q, dvd_q[W_TOTAL-1]};
        qbit = (r_sh >= {1'b0, peak_q});

        y_full = prod_q >>> W_FRAC;
        if (y_full > PMAX)      y_sat = SMAX;
        else if (y_full < PMIN) y_sat = SMIN;
        else                    y_sat = y_full[W_TOTAL-1:0];
    end

    // Next-state and datapath control for the four-phase sample pipeline.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        d_d      = d_q;
        peak_d   = peak_q;
        hold_d   = hold_q;
        wptr_d   = wptr_q;
        fill_d   = fill_q;
        mem_d    = mem_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        g_d      = g_q;
        prod_d   = prod_q;
        o_data_d = o_data_q;
        o_gain_d = o_gain_q;
        o_ce_d   = 1'b0;
        ovr_d    = ovr_q | (i_ce && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (i_ce) begin
                    s_d     = s_sat;
                    state_d = MAG;
                end
            end
            MAG: begin
                // Oldest entry leaves before the new one overwrites its slot.
                d_d          = (fill_q < LA) ? '0 : mem_q[wptr_q];
                mem_d[wptr_q] = s_q;
                wptr_d       = (wptr_q == LAST_WP) ? '0 : wptr_q + 1'b1;
                if (fill_q < LA) fill_d = fill_q + 1'b1;
                // Hold the peak for a full line depth so it covers its own sample.
                if (m >= peak_q) begin
                    peak_d = m;
                    hold_d = LA;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    peak_d = (peak_q > RELEASE_STEP) ? peak_q - RELEASE_STEP : '0;
                end
                rem_d   = DVD[2*W_TOTAL-1:W_TOTAL];
                dvd_d   = DVD[W_TOTAL-1:0];
                quo_d   = '0;
                cnt_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                // Remainder stays below peak, so the subtraction fits W_TOTAL bits.
                rem_d = qbit ? (r_sh[W_TOTAL-1:0] - peak_q) : r_sh[W_TOTAL-1:0];
                dvd_d = {dvd_q[W_TOTAL-2:0], 1'b0};
                quo_d = {quo_q[W_TOTAL-3:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DV) begin
                    g_d     = (peak_q <= CEIL_LIN) ? ONE : {quo_q, qbit};
                    cnt_d   = '0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (cnt_q == '0) begin
                    prod_d = d_q * $signed({1'b0, g_q});
                    cnt_d  = 1'b1;
                end else begin
                    o_data_d = y_sat;
                    o_gain_d = g_q;
                    o_ce_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset drops any sample in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            d_q      <= '0;
            peak_q   <= '0;
            hold_q   <= '0;
            wptr_q   <= '0;
            fill_q   <= '0;
            for (int i = 0; i < LOOKAHEAD; i++) mem_q[i] <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            g_q      <= ONE;
            prod_q   <= '0;
            o_data_q <= '0;
            o_gain_q <= ONE;
            o_ce_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            d_q      <= d_d;
            peak_q   <= peak_d;
            hold_q   <= hold_d;
            wptr_q   <= wptr_d;
            fill_q   <= fill_d;
            mem_q    <= mem_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            g_q      <= g_d;
            prod_q   <= prod_d;
            o_data_q <= o_data_d;
            o_gain_q <= o_gain_d;
            o_ce_q   <= o_ce_d;
            ovr_q    <= ovr_d;
        end
    end

    assign o_data    = o_data_q;
    assign o_ce      = o_ce_q;
    assign o_gain    = o_gain_q;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_lmakeup_limiter.sv
// Directed bench for lmakeup_limiter: hand-computed outputs, latency and flags.
module tb_lmakeup_limiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ce = 1'b0;
    logic [15:0] i_data = '0;
    logic [15:0] o_data;
    logic        o_ce;
    logic [15:0] o_gain;
    logic        o_overrun;

    int total = 0;
    int bad   = 0;

    lmakeup_limiter dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ce      (i_ce),
        .i_data    (i_data),
        .o_data    (o_data),
        .o_ce      (o_ce),
        .o_gain    (o_gain),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_ce    = 1'b0;
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
    endtask

    // One sample, 24-cycle spacing; checks the 20-cycle latency and 1-cycle strobe.
    task automatic send(input logic [15:0] x, output logic [15:0] y, output logic [15:0] g);
        int cnt;
        i_data = x;
        i_ce   = 1'b1;
        @(posedge i_clk);
        #1 i_ce = 1'b0;
        cnt = 1;
        while (!o_ce && cnt < 40) begin
            @(posedge i_clk);
            #1 cnt++;
        end
        chk("latency", cnt, 20);
        y = o_data;
        g = o_gain;
        @(posedge i_clk);
        #1 chk("ce_one_cycle", {31'd0, o_ce}, 0);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [15:0] y, g;
        int n, at;

        // Reset state
        do_reset();
        chk("rst_data", o_data, 16'h0000);
        chk("rst_ce", {31'd0, o_ce}, 0);
        chk("rst_gain", o_gain, 16'h8000);
        chk("rst_ovr", {31'd0, o_overrun}, 0);

        // 0x2000 * 1.5 = 0x3000, below ceiling: unity gain, 8-sample delay
        for (int i = 0; i < 12; i++) begin
            send(16'h2000, y, g);
            chk("t1_data", y, (i < 8) ? 16'h0000 : 16'h3000);
            chk("t1_gain", g, 16'h8000);
        end

        // 0x7000 saturates to 0x7FFF; gain floor(0x7000*2^15/0x7FFF)=0x7000
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(16'h7000, y, g);
            chk("t2_data", y, (i < 8) ? 16'h0000 : 16'h6FFF);
            chk("t2_gain", g, 16'h7000);
        end

        // Impulse 0x5000 -> 0x7800 at sample 8 among zeros
        do_reset();
        for (int i = 0; i <= 144; i++) begin
            send((i == 8) ? 16'h5000 : 16'h0000, y, g);
            if (i < 8) chk("t3_gain_pre", g, 16'h8000);
            if (i >= 8 && i <= 16) chk("t3_gain_hold", g, 16'h7777);
            if (i == 16) chk("t3_impulse_out", y, 16'h6FFF);
            if (i == 17) begin
                chk("t3_gain_rel", g, 16'h7787);
                chk("t3_after_out", y, 16'h0000);
            end
            if (i == 143) chk("t3_gain_near", g, 16'h7FED);
            if (i == 144) chk("t3_gain_back", g, 16'h8000);
        end

        // Full-scale negative: -32768 -> gain 0x7000 -> 0x9000
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(16'h8000, y, g);
            chk("t4_data", y, (i < 8) ? 16'h0000 : 16'h9000);
            chk("t4_gain", g, 16'h7000);
        end

        // Overrun: second i_ce 10 cycles later is dropped
        do_reset();
        i_data = 16'h1000;
        n = 0;
        at = 0;
        for (int c = 0; c < 45; c++) begin
            i_ce = (c == 0 || c == 10);
            @(posedge i_clk);
            #1 i_ce = 1'b0;
            if (o_ce) begin
                n++;
                at = c + 1;
            end
        end
        chk("t5_ce_count", n, 1);
        chk("t5_ce_at", at, 20);
        chk("t5_ovr", {31'd0, o_overrun}, 1);
        send(16'h1000, y, g);
        chk("t5_next_data", y, 16'h0000);
        chk("t5_ovr_sticky", {31'd0, o_overrun}, 1);

        // Reset mid-DIV aborts the sample and empties the delay line
        do_reset();
        for (int i = 0; i < 9; i++) send(16'h2000, y, g);
        chk("t6_pre_data", y, 16'h3000);
        i_data = 16'h2000;
        i_ce   = 1'b1;
        @(posedge i_clk);
        #1 i_ce = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        n = 0;
        repeat (30) begin
            @(posedge i_clk);
            #1 if (o_ce) n++;
        end
        chk("t6_no_ce", n, 0);
        chk("t6_rst_data", o_data, 16'h0000);
        chk("t6_rst_gain", o_gain, 16'h8000);
        chk("t6_rst_ovr", {31'd0, o_overrun}, 0);
        for (int i = 0; i < 9; i++) begin
            send(16'h2000, y, g);
            chk("t6_data", y, (i < 8) ? 16'h0000 : 16'h3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lmakeup_limiter.md
Name: lmakeup_limiter

Overview:
- Output stage placed directly after the linear compressor.
- Applies fixed make-up gain with saturation, then a lookahead brick-wall peak limiter so that |o_data| never exceeds CEIL_LIN.
- Strobe-driven: consumes the compressor's Q1.15 sample plus its one-cycle o_ce as this block's i_data/i_ce, and emits one limited Q1.15 sample per accepted input.

Parameters:
- W_TOTAL, 16, sample width (Q1.15 signed).
- W_FRAC, 15, fractional bits.
- MAKEUP_GAIN, 16'h6000, unsigned Q2.14 make-up gain (1.5).
- CEIL_LIN, 16'h7000, limiter ceiling, Q1.15 magnitude, range 1..32767.
- LOOKAHEAD, 8, delay-line depth in samples, range 1..64.
- RELEASE_STEP, 16'h0010, peak decay per sample once hold expires.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ce  in  1  input sample strobe.
- i_data  in  W_TOTAL  signed Q1.15 sample.
- o_data  out  W_TOTAL  signed Q1.15 limited sample.
- o_ce  out  1  one-cycle output strobe.
- o_gain  out  W_TOTAL  current limiter gain, unsigned Q1.15; 16'h8000 = 1.0.
- o_overrun  out  1  sticky: a sample was dropped.

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset values:
  - o_data=0, o_ce=0, o_gain=16'h8000, o_overrun=0.
  - peak=0, hold=0, write pointer=0, fill counter=0, FSM=IDLE.
  - Reset wins over i_ce in the same cycle and aborts any sample in flight; no o_ce follows.
- FSM IDLE -> MAG -> DIV -> APPLY -> IDLE:
  - i_ce is accepted only in IDLE.
  - i_ce in any other state drops the sample and sets o_overrun (cleared only by reset).
- Fixed latency: o_ce pulses exactly 20 cycles after the accepting i_ce cycle, whether or not division is needed.
  - FSM is back in IDLE in the o_ce cycle, so i_ce may coincide with o_ce.
  - Minimum legal i_ce spacing is 20 cycles.
- IDLE (accept):
  - s = (i_data * MAKEUP_GAIN) >>> 14, arithmetic shift (floor), saturated to [-32768, 32767]; register s.
- MAG (1 cycle):
  - m = |s|, with -32768 mapping to 32767.
  - Read oldest delay-line entry d (treated as 0 while fill counter < LOOKAHEAD), then write s at the pointer; pointer wraps modulo LOOKAHEAD.
  - Fill counter saturates at LOOKAHEAD.
  - Peak update:
    - If m >= peak: peak=m, hold=LOOKAHEAD.
    - Else if hold != 0: hold--.
    - Else: peak = max(peak - RELEASE_STEP, 0).
- DIV (16 cycles):
  - If peak <= CEIL_LIN: g = 16'h8000.
  - Else: g = floor(CEIL_LIN * 2^15 / peak), using a 16-iteration restoring divider, one bit per cycle. g is always < 16'h8000.
  - The 16 cycles are spent in both cases.
- APPLY (2 cycles):
  - y = (d * g) >>> 15, floor, clamped to [-32768, 32767].
  - Register o_data=y and o_gain=g; pulse o_ce.
- Lookahead guarantee: a sample's magnitude stays in peak until that same sample leaves the delay line, so |o_data| <= CEIL_LIN always holds.
- Sample delay: output k corresponds to input k - LOOKAHEAD. The first LOOKAHEAD outputs after reset are 0.
- o_data and o_gain hold their value between o_ce pulses.

Test Plan:
- Reset, then 12 samples i_data=0x2000, spaced 24 cycles -> s=0x3000; first 8 o_data=0, then 0x3000; o_gain=0x8000; each o_ce exactly 20 cycles after its i_ce.
- Constant i_data=0x7000 -> s saturates to 0x7FFF; o_gain=0x7000; after fill, o_data=0x6FFF.
- Impulse 0x5000 among zeros -> s=0x7800; o_gain=0x7777 from the impulse's sample through 8 samples later. The impulse emerges as o_data=0x6FFF. Peak then decays by 0x10 per sample and o_gain climbs back to 0x8000 once peak <= 0x7000.
- i_data=0x8000 repeated -> s=-32768, m=32767; after fill, o_data = floor(-32768*0x7000/32768) = 0x9000; |o_data| <= CEIL_LIN.
- Two i_ce pulses 10 cycles apart -> second sample dropped, o_overrun=1 and stays 1; exactly one o_ce; the next i_ce at >=20 cycles is processed normally.
- i_reset asserted for 1 cycle mid-DIV -> no o_ce for that sample; all outputs return to reset values. The next 8 outputs are 0 (fill counter cleared).
